ide_cycle_sequencer: RTL and testbench

Sequences every IDE register/data access decoded for the IDE window on the 68000 bus. Converts one qualified bus cycle (AS_n low, ide_access high) into a timed IDE transaction: address/CS setup, IOR_n/IOW_n strobe width, hold/recovery. Issues dtack only after the strobe completes. Strobe and recovery lengths come from a PIO-mode register that the driver writes. Sits between the address decoder/autoconfig and the IDE buffer/strobe pins, clocked by CLK7M.

---
 rtl/ide_timing_pkg.sv | 34 +++
 rtl/ide_cycle_sequencer_if.sv | 45 ++++
 rtl/ide_timing_counter.sv | 29 ++
 rtl/ide_cycle_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_ide_cycle_sequencer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ide_timing_pkg.sv
// Purpose : shared types, PIO timing tables and helpers for the IDE cycle sequencer.
// Latency : n/a (constants and pure functions only).
// Backpressure: n/a.
// Contents: ide_state_t, MODE_W, CNT_W, ACTIVE_CYC/RECOVER_CYC tables, IORDY_TIMEOUT, active_load().
// Optional feature macro used by the block: IDE_IORDY_EN (IORDY strobe extension).
package ide_timing_pkg;

   localparam int MODE_W = 2;
   localparam int CNT_W  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD,
      ST_ACK,
      ST_RECOVER
   } ide_state_t;

   // Strobe-low and post-transaction recovery lengths in CLK7M cycles, by PIO mode.
   localparam logic [2:0] ACTIVE_CYC  [0:3] = '{3'd4, 3'd3, 3'd2, 3'd1};
   localparam logic [1:0] RECOVER_CYC [0:3] = '{2'd2, 2'd1, 2'd1, 2'd0};

   // Maximum number of extra strobe cycles granted while IORDY is low.
   localparam logic [3:0] IORDY_TIMEOUT = 4'd15;

   // Counter load value for the strobe phase: ACTIVE_CYC-1 always fits in two bits.
   function automatic logic [CNT_W-1:0] active_load(input logic [MODE_W-1:0] mode);
      logic [2:0] t;
      t = ACTIVE_CYC[mode] - 3'd1;
      return t[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/ide_cycle_sequencer_if.sv
// Purpose : bundle of bus-side request, mode-register and IDE strobe-side signals of the sequencer.
// Latency : n/a (wiring only).
// Backpressure: dtack is held until AS_n rises; no other flow control.
// Ports   : master = decoder/bus side (drives AS_n, RW, ide_access, ide_enable, mode_wr, mode_din[, IORDY]),
//           slave  = sequencer (drives IOR_n, IOW_n, cs_en, buf_oe, dtack, busy, pio_mode[, iordy_timeout]).
// Optional: IDE_IORDY_EN adds IORDY and iordy_timeout.
interface ide_cycle_sequencer_if;

   logic                              AS_n;
   logic                              RW;
   logic                              ide_access;
   logic                              ide_enable;
   logic                              mode_wr;
   logic [ide_timing_pkg::MODE_W-1:0] mode_din;
   logic                              IOR_n;
   logic                              IOW_n;
   logic                              cs_en;
   logic                              buf_oe;
   logic                              dtack;
   logic                              busy;
   logic [ide_timing_pkg::MODE_W-1:0] pio_mode;
`ifdef IDE_IORDY_EN
   logic                              IORDY;
   logic                              iordy_timeout;
`endif

   modport master (
      output AS_n, RW, ide_access, ide_enable, mode_wr, mode_din,
      input  IOR_n, IOW_n, cs_en, buf_oe, dtack, busy, pio_mode
`ifdef IDE_IORDY_EN
      , output IORDY
      , input  iordy_timeout
`endif
   );

   modport slave (
      input  AS_n, RW, ide_access, ide_enable, mode_wr, mode_din,
      output IOR_n, IOW_n, cs_en, buf_oe, dtack, busy, pio_mode
`ifdef IDE_IORDY_EN
      , input  IORDY
      , output iordy_timeout
`endif
   );

endinterface

// File: rtl/ide_timing_counter.sv
// Purpose : loadable 2-bit down-counter with terminal-count flag, shared by all timed phases.
// Latency : load takes effect on the edge it is sampled; tc is combinational from the count register.
// Backpressure: none; counts down every cycle while non-zero, holds at zero.
// Ports   : CLK7M, RESET (sync, active-low), load, load_val -> tc (count == 0).
module ide_timing_counter
   import ide_timing_pkg::*;
(
   input  logic             CLK7M,
   input  logic             RESET,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             tc
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge CLK7M) begin
      if (!RESET) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign tc = (count == '0);

endmodule

// File: rtl/ide_cycle_sequencer.sv
// Purpose : turns one qualified 68000 bus cycle into a timed IDE read/write (setup, strobe, hold, ack, recovery).
// Latency : strobe falls SETUP_CYC+1 edges after the request edge; dtack SETUP_CYC+ACTIVE_CYC+HOLD_CYC+1 edges after.
// Backpressure: dtack held until AS_n rises; new requests ignored until the sequencer is back in IDLE.
// Ports   : CLK7M, RESET (sync, active-low), bus (ide_cycle_sequencer_if.slave).
// Optional: IDE_IORDY_EN enables IORDY strobe extension (up to 15 extra cycles) and the iordy_timeout pulse.
module ide_cycle_sequencer
   import ide_timing_pkg::*;
#(
   parameter int unsigned          SETUP_CYC    = 1,
   parameter int unsigned          HOLD_CYC     = 1,
   parameter logic [MODE_W-1:0]    DEFAULT_MODE = '0
) (
   input  logic                   CLK7M,
   input  logic                   RESET,
   ide_cycle_sequencer_if.slave   bus
);

   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

   ide_state_t        state, state_nxt;
   logic              dir_r, dir_nxt;        // 1 = read
   logic              tim_ld;
   logic [CNT_W-1:0]  act_r;                 // latched strobe-phase counter load
   logic [1:0]        rec_r;                 // latched recovery length
   logic [MODE_W-1:0] pio_mode_r;
   logic              cnt_load;
   logic [CNT_W-1:0]  cnt_val;
   logic              cnt_tc;
   logic              strobe_done;
   logic              recover_go;
   logic              request;
   logic              ior_n_r, iow_n_r, cs_en_r, buf_oe_r, dtack_r, busy_r;
`ifdef IDE_IORDY_EN
   logic [3:0]        ext_cnt, ext_nxt;
   logic              to_r, to_nxt;
`endif

   assign request = !bus.AS_n && bus.ide_access && bus.ide_enable;

   ide_timing_counter u_cnt (
      .CLK7M    (CLK7M),
      .RESET    (RESET),
      .load     (cnt_load),
      .load_val (cnt_val),
      .tc       (cnt_tc)
   );

   always_ff @(posedge CLK7M) begin
      if (!RESET) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      dir_nxt     = dir_r;
      tim_ld      = 1'b0;
      cnt_load    = 1'b0;
      cnt_val     = '0;
      strobe_done = 1'b0;
      recover_go  = 1'b0;
`ifdef IDE_IORDY_EN
      ext_nxt     = (state == ST_STROBE) ? ext_cnt : 4'd0;
      to_nxt      = 1'b0;
`endif

      unique case (state)
         ST_IDLE: begin
            if (request) begin
               dir_nxt  = bus.RW;
               tim_ld   = 1'b1;
               cnt_load = 1'b1;
               if (SETUP_CYC == 0) begin
                  // No setup phase: timing comes straight from the live mode register.
                  state_nxt = ST_STROBE;
                  cnt_val   = active_load(pio_mode_r);
               end else begin
                  state_nxt = ST_SETUP;
                  cnt_val   = SETUP_LD;
               end
            end
         end
         ST_SETUP: begin
            if (bus.AS_n) begin
               recover_go = 1'b1;
            end else if (cnt_tc) begin
               state_nxt = ST_STROBE;
               cnt_load  = 1'b1;
               cnt_val   = act_r;
            end
         end
         ST_STROBE: begin
            if (bus.AS_n) begin
               recover_go = 1'b1;
            end else if (cnt_tc) begin
               strobe_done = 1'b1;
`ifdef IDE_IORDY_EN
               // Drive not ready at the table end: stretch the strobe, bounded by the timeout.
               if (!bus.IORDY) begin
                  if (ext_cnt == IORDY_TIMEOUT) begin
                     to_nxt = 1'b1;
                  end else begin
                     strobe_done = 1'b0;
                     ext_nxt     = ext_cnt + 4'd1;
                  end
               end
`endif
            end
         end
         ST_HOLD: begin
            if (bus.AS_n)     recover_go = 1'b1;
            else if (cnt_tc)  state_nxt  = ST_ACK;
         end
         ST_ACK: begin
            if (bus.AS_n) recover_go = 1'b1;
         end
         ST_RECOVER: begin
            if (cnt_tc) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase

      if (strobe_done) begin
         if (HOLD_CYC == 0) begin
            state_nxt = ST_ACK;
         end else begin
            state_nxt = ST_HOLD;
            cnt_load  = 1'b1;
            cnt_val   = HOLD_LD;
         end
      end

      // Both normal completion and aborts go through recovery when the mode asks for it.
      if (recover_go) begin
         if (rec_r == 2'd0) begin
            state_nxt = ST_IDLE;
         end else begin
            state_nxt = ST_RECOVER;
            cnt_load  = 1'b1;
            cnt_val   = rec_r - 2'd1;
         end
      end
   end

   // Outputs are decoded from the next state and registered, so they change only on
   // clock edges and the two strobes can never be low together.
   always_ff @(posedge CLK7M) begin
      if (!RESET) begin
         dir_r      <= 1'b0;
         act_r      <= '0;
         rec_r      <= '0;
         pio_mode_r <= DEFAULT_MODE;
         ior_n_r    <= 1'b1;
         iow_n_r    <= 1'b1;
         cs_en_r    <= 1'b0;
         buf_oe_r   <= 1'b0;
         dtack_r    <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         dir_r <= dir_nxt;
         if (tim_ld) begin
            act_r <= active_load(pio_mode_r);
            rec_r <= RECOVER_CYC[pio_mode_r];
         end
         if (bus.mode_wr) pio_mode_r <= bus.mode_din;
         ior_n_r  <= !((state_nxt == ST_STROBE) &&  dir_nxt);
         iow_n_r  <= !((state_nxt == ST_STROBE) && !dir_nxt);
         cs_en_r  <= state_nxt inside {ST_SETUP, ST_STROBE, ST_HOLD, ST_ACK};
         buf_oe_r <= state_nxt inside {ST_SETUP, ST_STROBE, ST_HOLD, ST_ACK};
         dtack_r  <= (state_nxt == ST_ACK);
         busy_r   <= (state_nxt != ST_IDLE);
      end
   end

`ifdef IDE_IORDY_EN
   always_ff @(posedge CLK7M) begin
      if (!RESET) begin
         ext_cnt <= 4'd0;
         to_r    <= 1'b0;
      end else begin
         ext_cnt <= ext_nxt;
         to_r    <= to_nxt;
      end
   end

   assign bus.iordy_timeout = to_r;
`endif

   assign bus.IOR_n    = ior_n_r;
   assign bus.IOW_n    = iow_n_r;
   assign bus.cs_en    = cs_en_r;
   assign bus.buf_oe   = buf_oe_r;
   assign bus.dtack    = dtack_r;
   assign bus.busy     = busy_r;
   assign bus.pio_mode = pio_mode_r;

endmodule

// File: tb/tb_ide_cycle_sequencer.sv
// Purpose : directed self-checking bench for ide_cycle_sequencer (SETUP_CYC=1, HOLD_CYC=1, DEFAULT_MODE=0).
// Latency : edges are numbered from the request-sampling edge (edge 1); outputs sampled 1 ns after each edge.
// Backpressure: AS_n is released by the bench to end each ACK phase.
// Ports   : drives the master side of ide_cycle_sequencer_if; IDE_IORDY_EN adds the IORDY cases.
module tb_ide_cycle_sequencer;

   logic CLK7M = 1'b0;
   logic RESET;
   int   checks = 0;
   int   errors = 0;
   int   ior_lo, iow_lo, ack_at, both_lo, to_cnt;

   ide_cycle_sequencer_if bus_if ();

   ide_cycle_sequencer #(
      .SETUP_CYC    (1),
      .HOLD_CYC     (1),
      .DEFAULT_MODE (2'd0)
   ) dut (
      .CLK7M (CLK7M),
      .RESET (RESET),
      .bus   (bus_if.slave)
   );

   always #5 CLK7M = ~CLK7M;

   task automatic tick();
      @(posedge CLK7M);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Runs edges start, start+1, ... until dtack is seen (bounded), tallying strobe-low cycles.
   task automatic measure(input int start, output int r_lo, output int w_lo,
                          output int ack_edge, output int both, output int tos);
      int n;
      r_lo = 0; w_lo = 0; ack_edge = -1; both = 0; tos = 0;
      n = start;
      while (ack_edge < 0 && n < start + 60) begin
         tick();
         if (bus_if.IOR_n === 1'b0) r_lo++;
         if (bus_if.IOW_n === 1'b0) w_lo++;
         if (bus_if.IOR_n === 1'b0 && bus_if.IOW_n === 1'b0) both++;
`ifdef IDE_IORDY_EN
         if (bus_if.iordy_timeout === 1'b1) tos++;
`endif
         if (bus_if.dtack === 1'b1) ack_edge = n;
         n++;
      end
   endtask

   task automatic set_mode(input logic [1:0] m);
      bus_if.mode_wr  = 1'b1;
      bus_if.mode_din = m;
      tick();
      bus_if.mode_wr  = 1'b0;
   endtask

   initial begin
      RESET             = 1'b0;
      bus_if.AS_n       = 1'b1;
      bus_if.RW         = 1'b1;
      bus_if.ide_access = 1'b0;
      bus_if.ide_enable = 1'b1;
      bus_if.mode_wr    = 1'b0;
      bus_if.mode_din   = 2'd0;
`ifdef IDE_IORDY_EN
      bus_if.IORDY      = 1'b1;
`endif
      tick(); tick();
      chk("rst_ior",   bus_if.IOR_n,    1);
      chk("rst_iow",   bus_if.IOW_n,    1);
      chk("rst_cs",    bus_if.cs_en,    0);
      chk("rst_buf",   bus_if.buf_oe,   0);
      chk("rst_dtack", bus_if.dtack,    0);
      chk("rst_busy",  bus_if.busy,     0);
      chk("rst_mode",  bus_if.pio_mode, 0);
      RESET = 1'b1;
      tick();

      // 1: read, mode 0
      bus_if.ide_access = 1'b1;
      bus_if.RW         = 1'b1;
      bus_if.AS_n       = 1'b0;
      tick(); // edge 1
      chk("t1_e1_busy", bus_if.busy,   1);
      chk("t1_e1_cs",   bus_if.cs_en,  1);
      chk("t1_e1_buf",  bus_if.buf_oe, 1);
      chk("t1_e1_ior",  bus_if.IOR_n,  1);
      for (int e = 2; e <= 5; e++) begin
         tick();
         chk($sformatf("t1_e%0d_ior", e), bus_if.IOR_n, 0);
         chk($sformatf("t1_e%0d_iow", e), bus_if.IOW_n, 1);
      end
      tick(); // edge 6
      chk("t1_e6_ior",   bus_if.IOR_n, 1);
      chk("t1_e6_dtack", bus_if.dtack, 0);
      chk("t1_e6_cs",    bus_if.cs_en, 1);
      tick(); // edge 7
      chk("t1_e7_dtack", bus_if.dtack, 1);
      tick(); // edge 8, AS_n still low
      chk("t1_e8_dtack", bus_if.dtack, 1);
      bus_if.AS_n = 1'b1;
      tick();
      chk("t1_rel_dtack", bus_if.dtack,  0);
      chk("t1_rel_cs",    bus_if.cs_en,  0);
      chk("t1_rel_buf",   bus_if.buf_oe, 0);
      chk("t1_rec1_busy", bus_if.busy,   1);
      tick();
      chk("t1_rec2_busy", bus_if.busy,   1);
      tick();
      chk("t1_idle_busy", bus_if.busy,   0);

      // 2: write, mode 3, then a back-to-back request
      set_mode(2'd3);
      chk("t2_mode", bus_if.pio_mode, 3);
      bus_if.RW   = 1'b0;
      bus_if.AS_n = 1'b0;
      measure(1, ior_lo, iow_lo, ack_at, both_lo, to_cnt);
      chk("t2_iow_lo", iow_lo, 1);
      chk("t2_ior_lo", ior_lo, 0);
      chk("t2_ack_at", ack_at, 4);
      bus_if.AS_n = 1'b1;
      tick();
      chk("t2_rel_dtack", bus_if.dtack, 0);
      chk("t2_rel_busy",  bus_if.busy,  0);
      bus_if.AS_n = 1'b0;
      tick();
      chk("t2_b2b_busy", bus_if.busy,  1);
      chk("t2_b2b_cs",   bus_if.cs_en, 1);
      measure(2, ior_lo, iow_lo, ack_at, both_lo, to_cnt);
      chk("t2_b2b_iow_lo", iow_lo, 1);
      chk("t2_b2b_ack_at", ack_at, 4);
      bus_if.AS_n = 1'b1;
      tick();
      chk("t2_b2b_idle", bus_if.busy, 0);

      // 3: abort during STROBE, mode 0
      set_mode(2'd0);
      bus_if.RW   = 1'b1;
      bus_if.AS_n = 1'b0;
      tick(); tick(); // edges 1, 2
      chk("t3_e2_ior", bus_if.IOR_n, 0);
      tick();         // edge 3
      bus_if.AS_n = 1'b1;
      tick();         // edge 4
      chk("t3_ab_ior",   bus_if.IOR_n,  1);
      chk("t3_ab_cs",    bus_if.cs_en,  0);
      chk("t3_ab_buf",   bus_if.buf_oe, 0);
      chk("t3_ab_dtack", bus_if.dtack,  0);
      chk("t3_ab_busy",  bus_if.busy,   1);
      tick();
      chk("t3_rec_dtack", bus_if.dtack, 0);
      chk("t3_rec_busy",  bus_if.busy,  1);
      tick();
      chk("t3_idle_busy", bus_if.busy,  0);

      // 4: mode write during an in-flight mode-0 read
      bus_if.AS_n = 1'b0;
      tick(); tick(); // edges 1, 2
      bus_if.mode_wr  = 1'b1;
      bus_if.mode_din = 2'd2;
      tick();         // edge 3
      bus_if.mode_wr  = 1'b0;
      chk("t4_mode",   bus_if.pio_mode, 2);
      chk("t4_e3_ior", bus_if.IOR_n,    0);
      measure(4, ior_lo, iow_lo, ack_at, both_lo, to_cnt);
      chk("t4_rest_ior_lo", ior_lo, 2);
      chk("t4_ack_at",      ack_at, 7);
      bus_if.AS_n = 1'b1;
      tick(); tick();
      chk("t4_rec_busy", bus_if.busy, 1);
      tick();
      chk("t4_idle_busy", bus_if.busy, 0);
      bus_if.AS_n = 1'b0;
      measure(1, ior_lo, iow_lo, ack_at, both_lo, to_cnt);
      chk("t4_m2_ior_lo", ior_lo, 2);
      chk("t4_m2_ack_at", ack_at, 5);
      bus_if.AS_n = 1'b1;
      tick();
      chk("t4_m2_rec_busy", bus_if.busy, 1);
      tick();
      chk("t4_m2_idle", bus_if.busy, 0);

      // 5: reset mid-STROBE, then requests with ide_enable low
      bus_if.AS_n = 1'b0;
      tick(); tick();
      chk("t5_strobe", bus_if.IOR_n, 0);
      RESET = 1'b0;
      tick();
      chk("t5_ior",   bus_if.IOR_n,    1);
      chk("t5_iow",   bus_if.IOW_n,    1);
      chk("t5_cs",    bus_if.cs_en,    0);
      chk("t5_buf",   bus_if.buf_oe,   0);
      chk("t5_dtack", bus_if.dtack,    0);
      chk("t5_busy",  bus_if.busy,     0);
      chk("t5_mode",  bus_if.pio_mode, 0);
      RESET       = 1'b1;
      bus_if.AS_n = 1'b1;
      tick();
      bus_if.ide_enable = 1'b0;
      bus_if.AS_n       = 1'b0;
      tick(); tick();
      chk("t5_dis_busy", bus_if.busy,  0);
      chk("t5_dis_cs",   bus_if.cs_en, 0);
      bus_if.AS_n       = 1'b1;
      bus_if.ide_enable = 1'b1;
      tick();

`ifdef IDE_IORDY_EN
      // 6a: IORDY low for 3 cycles at the strobe end, mode 0
      bus_if.AS_n = 1'b0;
      for (int e = 1; e <= 5; e++) tick();
      bus_if.IORDY = 1'b0;
      tick(); tick(); tick(); // edges 6..8
      chk("t6_ext_ior", bus_if.IOR_n, 0);
      bus_if.IORDY = 1'b1;
      tick();                 // edge 9
      chk("t6_end_ior", bus_if.IOR_n, 1);
      chk("t6_no_to",   bus_if.iordy_timeout, 0);
      tick();                 // edge 10
      chk("t6_dtack", bus_if.dtack, 1);
      bus_if.AS_n = 1'b1;
      tick(); tick(); tick();
      // 6b: IORDY stuck low
      bus_if.IORDY = 1'b0;
      bus_if.AS_n  = 1'b0;
      measure(1, ior_lo, iow_lo, ack_at, both_lo, to_cnt);
      chk("t6_stuck_ior_lo", ior_lo, 19);
      chk("t6_stuck_ack_at", ack_at, 22);
      chk("t6_stuck_to",     to_cnt, 1);
      bus_if.IORDY = 1'b1;
      bus_if.AS_n  = 1'b1;
      tick(); tick(); tick();
      chk("t6_idle", bus_if.busy, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
